spinn_receiver: RTL and testbench
=================================

Name: spinn_receiver

Overview:
- Receiving end of the SpiNNaker 2-of-7 NRZ link. It is the counterpart of the link transmitter driver.
- Watches the 7 asynchronous link wires, decodes one symbol for every 2-wire transition and returns an ACK toggle per consumed symbol.
- Assembles nibbles LSB-first into a 40- or 72-bit packet.
- Presents each complete packet on the synchronous valid/ready packet interface used across the codebase.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchroniser on SL_DATA_2OF7_IN (minimum 2).
- PKT_BITS, 72, width of PKT_DATA_OUT. Long packets fill all 72 bits; short packets fill [39:0] and zero [71:40].

Ports:
- CLK_IN  in  1  system clock, single clock domain.
- RESET_IN  in  1  reset, synchronous, active-low.
- SL_DATA_2OF7_IN  in  7  asynchronous NRZ 2-of-7 link data.
- SL_ACK_OUT  out  1  NRZ acknowledge; toggles once per consumed symbol.
- PKT_DATA_OUT  out  PKT_BITS  assembled packet.
- PKT_VLD_OUT  out  1  packet valid.
- PKT_RDY_IN  in  1  downstream ready.
- PKT_LONG_OUT  out  1  packet is a long (72-bit) packet; qualified by PKT_VLD_OUT.
- FRAME_ERR_OUT  out  1  one-cycle pulse on a framing or symbol error.
- PARITY_ERR_OUT  out  1  one-cycle pulse on a parity failure (see Optional Feature).

Behaviour:
- Reset (RESET_IN=0 at a clock edge):
  - SL_ACK_OUT=0, PKT_VLD_OUT=0, PKT_DATA_OUT=0, PKT_LONG_OUT=0, both error outputs 0.
  - Symbol reference register = 7'b0, synchroniser cleared, nibble count=0, state=IDLE.
  - Reset mid-packet discards the partial packet; no ACK toggles during reset.
- Symbol detection:
  - chg = sync_data XOR reference. A symbol is present when popcount(chg) ≥ 2.
  - chg of 1 bit: wait, the link is still settling.
- Decode table (chg to symbol):
  - 0010001=0, 0010010=1, 0010100=2, 0011000=3
  - 0100001=4, 0100010=5, 0100100=6, 0101000=7
  - 1000001=8, 1000010=9, 1000100=10, 1001000=11
  - 0000011=12, 0000110=13, 0001100=14, 0001001=15
  - 1100000=EOP
  - Any other 2-bit pattern, or ≥3 bits changed: invalid symbol.
- Consume a symbol:
  - reference <= sync_data, SL_ACK_OUT toggles on the next edge.
  - Latency from wire change to ACK toggle is SYNC_STAGES+1 cycles.
  - Data nibbles and invalid symbols are always consumed immediately.
  - An EOP that would deliver a packet is held, not acked and not consumed, while PKT_VLD_OUT=1 and PKT_RDY_IN=0. This is link back-pressure.
- Nibble placement:
  - Nibble k (count k, 0-based) is written to bits [4k+3:4k].
  - Nibble 0 bit1 sets long: long packet = 18 nibbles, short = 10.
- State machine:
  - IDLE (count=0):
    - data nibble -> store, count=1, go RECV.
    - EOP -> FRAME_ERR pulse, stay IDLE.
    - invalid -> FRAME_ERR, go DROP.
  - RECV:
    - data with count < limit -> store, count+1.
    - data with count == limit -> FRAME_ERR, go DROP.
    - EOP with count == limit -> deliver, count=0, go IDLE.
    - EOP with count ≠ limit -> FRAME_ERR, discard, go IDLE.
    - invalid -> FRAME_ERR, go DROP.
  - DROP: consume everything; EOP -> IDLE with no error pulse.
- Delivery:
  - On the cycle after EOP is consumed: PKT_VLD_OUT=1, PKT_DATA_OUT and PKT_LONG_OUT are loaded.
  - Data and long flag stay stable until PKT_VLD_OUT && PKT_RDY_IN at a clock edge; PKT_VLD_OUT then drops on the next edge.
  - The next packet's nibbles can be received while the output is held. Only its EOP stalls.
  - Delivery and handshake on the same edge is permitted: a held EOP is consumed on the same edge as the handshake, and PKT_VLD_OUT stays 1 with the new data.

Optional Feature:
- Macro: SPINN_RX_PARITY_CHK_EN.
- Defined:
  - At EOP with count == limit, check odd parity over the 40 or 72 received bits.
  - Even parity: the packet is not delivered, PARITY_ERR_OUT pulses 1 cycle, state goes IDLE, and the EOP is acked normally.
- Undefined: no check is made, every framed packet is delivered, PARITY_ERR_OUT is tied 0.

Test Plan:
- Short packet: drive the symbols of 40'h00000000_01 (ten NRZ symbols, first symbol 7'b0010010, then EOP), one symbol per ACK toggle -> PKT_VLD_OUT=1, PKT_DATA_OUT=72'h01, PKT_LONG_OUT=0, exactly 11 ACK toggles.
- Long packet: nibble0=4'h2 followed by 17 nibbles of 4'hF, then EOP -> PKT_LONG_OUT=1, PKT_DATA_OUT=72'hFF_FFFF_FFFF_FFFF_FFF2.
- Back-pressure: hold PKT_RDY_IN=0 with a packet held, then send a full second packet -> 10 data ACKs occur, the EOP is not acked. Raise PKT_RDY_IN -> EOP acked the same cycle, the second packet appears next.
- Framing: EOP after 5 nibbles -> FRAME_ERR_OUT single pulse, no PKT_VLD_OUT, next good packet delivered intact.
- Invalid symbol: a 3-wire change mid-packet -> FRAME_ERR pulse, ACK toggles, following nibbles are dropped until EOP with no further error, next packet delivered.
- Parity (with SPINN_RX_PARITY_CHK_EN): short packet 40'h0 -> PARITY_ERR_OUT pulse, no delivery. 40'h01 -> delivered. Without the macro, 40'h0 is delivered.

Source files
------------

// File: rtl/spinn_receiver.sv
// spinn_receiver: SpiNNaker 2-of-7 NRZ link receiver, nibble assembly.
// Optional odd-parity check on framed packets: SPINN_RX_PARITY_CHK_EN.
module spinn_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int PKT_BITS    = 72
) (
   input  logic                CLK_IN,
   input  logic                RESET_IN,
   input  logic [6:0]          SL_DATA_2OF7_IN,
   output logic                SL_ACK_OUT,
   output logic [PKT_BITS-1:0] PKT_DATA_OUT,
   output logic                PKT_VLD_OUT,
   input  logic                PKT_RDY_IN,
   output logic                PKT_LONG_OUT,
   output logic                FRAME_ERR_OUT,
   output logic                PARITY_ERR_OUT
);

   localparam logic [6:0] EOP_C = 7'b1100000;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

   state_t                      state_q, state_d;
   logic [SYNC_STAGES-1:0][6:0] sync_q;
   logic [6:0]                  ref_q;
   logic [6:0]                  sync_w;
   logic [6:0]                  chg;
   logic                        ack_q;
   logic [4:0]                  cnt_q;
   logic                        long_q;
   logic [PKT_BITS-1:0]         asm_q, asm_d;
   logic [PKT_BITS-1:0]         view;
   logic [PKT_BITS-1:0]         data_q;
   logic                        vld_q;
   logic                        plong_q;
   logic                        fe_q, fe_d;
   logic                        pe_q, pe_d;
   logic                        sym;
   logic [4:0]                  dec;
   logic                        is_data, is_eop, is_inv;
   logic [3:0]                  nib;
   logic [4:0]                  limit;
   logic                        full;
   logic                        hold;
   logic                        par_bad;
   logic                        consume, store, first, deliver;

   // Synchronise the asynchronous link wires
   always_ff @(posedge CLK_IN) begin
      if (!RESET_IN) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= SL_DATA_2OF7_IN;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_w = sync_q[SYNC_STAGES-1];
   assign chg    = sync_w ^ ref_q;
   assign sym    = ($countones(chg) > 1);

   // Map a 2-wire change pattern to {data flag, nibble}
   always_comb begin
      dec = 5'h00;
      case (chg)
         7'b0010001: dec = 5'h10;
         7'b0010010: dec = 5'h11;
         7'b0010100: dec = 5'h12;
         7'b0011000: dec = 5'h13;
         7'b0100001: dec = 5'h14;
         7'b0100010: dec = 5'h15;
         7'b0100100: dec = 5'h16;
         7'b0101000: dec = 5'h17;
         7'b1000001: dec = 5'h18;
         7'b1000010: dec = 5'h19;
         7'b1000100: dec = 5'h1A;
         7'b1001000: dec = 5'h1B;
         7'b0000011: dec = 5'h1C;
         7'b0000110: dec = 5'h1D;
         7'b0001100: dec = 5'h1E;
         7'b0001001: dec = 5'h1F;
         default:    dec = 5'h00;
      endcase
   end

   assign nib     = dec[3:0];
   assign is_data = sym & dec[4];
   assign is_eop  = sym & (chg == EOP_C);
   assign is_inv  = sym & ~is_data & ~is_eop;

   assign limit = long_q ? 5'd18 : 5'd10;
   assign full  = (cnt_q == limit);
   assign view  = long_q ? asm_q
                : {{(PKT_BITS-40){1'b0}}, asm_q[39:0]};

`ifdef SPINN_RX_PARITY_CHK_EN
   assign par_bad = ~(^view);
`else
   assign par_bad = 1'b0;
`endif

   // A deliverable EOP waits while the output slot is occupied
   assign hold = vld_q & ~PKT_RDY_IN & full & ~par_bad;

   // FSM state register
   always_ff @(posedge CLK_IN) begin
      if (!RESET_IN) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      if (sym) begin
         case (state_q)
            S_IDLE: begin
               if (is_data)     state_d = S_RECV;
               else if (is_inv) state_d = S_DROP;
            end
            S_RECV: begin
               unique case (1'b1)
                  is_data: if (full)  state_d = S_DROP;
                  is_eop:  if (!hold) state_d = S_IDLE;
                  default: state_d = S_DROP;
               endcase
            end
            S_DROP: if (is_eop) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs: symbol consumption, storage and error strobes
   always_comb begin
      consume = 1'b0;
      store   = 1'b0;
      first   = 1'b0;
      deliver = 1'b0;
      fe_d    = 1'b0;
      pe_d    = 1'b0;
      if (sym) begin
         consume = 1'b1;
         case (state_q)
            S_IDLE: begin
               store = is_data;
               first = is_data;
               fe_d  = ~is_data;
            end
            S_RECV: begin
               unique case (1'b1)
                  is_data: begin
                     store = ~full;
                     fe_d  = full;
                  end
                  is_eop: begin
                     consume = ~hold;
                     deliver = full & ~par_bad & ~hold;
                     pe_d    = full & par_bad;
                     fe_d    = ~full;
                  end
                  default: fe_d = 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Place the incoming nibble at its slot; a new packet starts clean
   always_comb begin
      asm_d = asm_q;
      if (first) asm_d = '0;
      for (int k = 0; k < 18; k++)
         if (store && (cnt_q == 5'(k)))
            asm_d[4*k +: 4] = nib;
   end

   // Link-side state: reference, ACK, nibble count, assembly buffer
   always_ff @(posedge CLK_IN) begin
      if (!RESET_IN) begin
         ref_q  <= '0;
         ack_q  <= 1'b0;
         cnt_q  <= '0;
         long_q <= 1'b0;
         asm_q  <= '0;
         fe_q   <= 1'b0;
         pe_q   <= 1'b0;
      end else begin
         if (consume) begin
            ref_q <= sync_w;
            ack_q <= ~ack_q;
         end
         if (store)        cnt_q <= cnt_q + 5'd1;
         else if (consume) cnt_q <= '0;
         if (first) long_q <= nib[1];
         asm_q <= asm_d;
         fe_q  <= fe_d;
         pe_q  <= pe_d;
      end
   end

   // Packet output slot with valid/ready handshake
   always_ff @(posedge CLK_IN) begin
      if (!RESET_IN) begin
         vld_q   <= 1'b0;
         data_q  <= '0;
         plong_q <= 1'b0;
      end else if (deliver) begin
         vld_q   <= 1'b1;
         data_q  <= view;
         plong_q <= long_q;
      end else if (vld_q && PKT_RDY_IN) begin
         vld_q <= 1'b0;
      end
   end

   assign SL_ACK_OUT    = ack_q;
   assign PKT_DATA_OUT  = data_q;
   assign PKT_VLD_OUT   = vld_q;
   assign PKT_LONG_OUT  = plong_q;
   assign FRAME_ERR_OUT = fe_q;

`ifdef SPINN_RX_PARITY_CHK_EN
   assign PARITY_ERR_OUT = pe_q;
`else
   assign PARITY_ERR_OUT = 1'b0 & pe_q;
`endif

endmodule

// File: tb/tb_spinn_receiver.sv
// tb_spinn_receiver: directed bench for the 2-of-7 link receiver.
// Table of packets plus hand sequences for back-pressure and errors.
module tb_spinn_receiver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  din = '0;
   logic        ack;
   logic [71:0] data;
   logic        vld;
   logic        rdy = 1'b0;
   logic        lng;
   logic        fe;
   logic        pe;

   int nchk = 0;
   int nfail = 0;

   int   ack_cnt = 0;
   int   fe_rise = 0;
   int   fe_hi = 0;
   int   pe_hi = 0;
   logic ack_prev = 1'b0;
   logic fe_prev = 1'b0;

   logic [6:0] codes [0:15];
   localparam logic [6:0] EOP = 7'b1100000;

   typedef struct {
      logic [71:0] pkt;
      int          n;
      logic [71:0] exp_d;
      logic        exp_l;
   } vec_t;

   vec_t vt [0:3];

   always #5 clk = ~clk;

   spinn_receiver #(.SYNC_STAGES(2), .PKT_BITS(72)) dut (
      .CLK_IN          (clk),
      .RESET_IN        (rst_n),
      .SL_DATA_2OF7_IN (din),
      .SL_ACK_OUT      (ack),
      .PKT_DATA_OUT    (data),
      .PKT_VLD_OUT     (vld),
      .PKT_RDY_IN      (rdy),
      .PKT_LONG_OUT    (lng),
      .FRAME_ERR_OUT   (fe),
      .PARITY_ERR_OUT  (pe)
   );

   always @(negedge clk) begin
      if (ack !== ack_prev) ack_cnt++;
      ack_prev = ack;
      if (fe === 1'b1) fe_hi++;
      if (fe === 1'b1 && fe_prev !== 1'b1) fe_rise++;
      fe_prev = fe;
      if (pe === 1'b1) pe_hi++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: sim time expired, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [71:0] got,
                        input logic [71:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic send_sym(input logic [6:0] c, input int maxc,
                           output int cyc);
      logic a0;
      a0  = ack;
      din = din ^ c;
      cyc = 0;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         if (ack !== a0) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic send_pkt(input logic [71:0] p, input int n,
                           input bit eop, output int miss);
      int cyc;
      logic [3:0] nb;
      miss = 0;
      for (int k = 0; k < n; k++) begin
         nb = p[4*k +: 4];
         send_sym(codes[nb], 20, cyc);
         if (cyc == 0) miss++;
      end
      if (eop) begin
         send_sym(EOP, 20, cyc);
         if (cyc == 0) miss++;
      end
   endtask

   task automatic pop(input string nm);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check(nm, 72'(vld), 72'd0);
   endtask

   task automatic good_pkt(input string nm, input int idx);
      int miss;
      send_pkt(vt[idx].pkt, vt[idx].n, 1'b1, miss);
      check({nm, "_miss"}, 72'(miss), 72'd0);
      check({nm, "_vld"}, 72'(vld), 72'd1);
      check({nm, "_data"}, data, vt[idx].exp_d);
      check({nm, "_long"}, 72'(lng), 72'(vt[idx].exp_l));
      pop({nm, "_pop"});
   endtask

   initial begin
      int cyc;
      int miss;
      int a0;
      int f0;
      int h0;
      int p0;
      logic ak;

      codes[0]  = 7'b0010001; codes[1]  = 7'b0010010;
      codes[2]  = 7'b0010100; codes[3]  = 7'b0011000;
      codes[4]  = 7'b0100001; codes[5]  = 7'b0100010;
      codes[6]  = 7'b0100100; codes[7]  = 7'b0101000;
      codes[8]  = 7'b1000001; codes[9]  = 7'b1000010;
      codes[10] = 7'b1000100; codes[11] = 7'b1001000;
      codes[12] = 7'b0000011; codes[13] = 7'b0000110;
      codes[14] = 7'b0001100; codes[15] = 7'b0001001;

      vt[0] = '{72'hFF_FFFF_FFFF_FFFF_FFF2, 18,
                72'hFF_FFFF_FFFF_FFFF_FFF2, 1'b1};
      vt[1] = '{72'hAB_CD00_0089_ABCD_EF0D, 10,
                72'h00_0000_0089_ABCD_EF0D, 1'b0};
      vt[2] = '{72'h01_2345_6789_ABCD_EF46, 18,
                72'h01_2345_6789_ABCD_EF46, 1'b1};
      vt[3] = '{72'h00_0000_00FF_FFFF_FFF1, 10,
                72'h00_0000_00FF_FFFF_FFF1, 1'b0};

      // reset state
      repeat (3) tick();
      check("rst_ack", 72'(ack), 72'd0);
      check("rst_vld", 72'(vld), 72'd0);
      check("rst_data", data, 72'd0);
      check("rst_long", 72'(lng), 72'd0);
      check("rst_fe", 72'(fe), 72'd0);
      check("rst_pe", 72'(pe), 72'd0);
      rst_n = 1'b1;
      tick();

      // short packet 40'h01 with latency and ACK count
      a0 = ack_cnt;
      send_sym(codes[1], 20, cyc);
      check("ack_latency", 72'(cyc), 72'd3);
      send_pkt(72'h0, 9, 1'b1, miss);
      check("short_miss", 72'(miss), 72'd0);
      check("short_vld", 72'(vld), 72'd1);
      check("short_data", data, 72'h01);
      check("short_long", 72'(lng), 72'd0);
      tick();
      check("short_acks", 72'(ack_cnt - a0), 72'd11);
      pop("short_pop");

      // table of framed packets
      for (int i = 0; i < 4; i++)
         good_pkt($sformatf("vec%0d", i), i);

      // back-pressure: second packet's EOP held until ready
      send_pkt(72'h01, 10, 1'b1, miss);
      check("bp_a_vld", 72'(vld), 72'd1);
      send_pkt(vt[1].pkt, 10, 1'b0, miss);
      check("bp_data_acks", 72'(miss), 72'd0);
      send_sym(EOP, 15, cyc);
      check("bp_eop_held", 72'(cyc), 72'd0);
      check("bp_a_data", data, 72'h01);
      ak  = ack;
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      check("bp_eop_ack", 72'(ack ^ ak), 72'd1);
      check("bp_b_vld", 72'(vld), 72'd1);
      check("bp_b_data", data, vt[1].exp_d);
      pop("bp_pop");

      // framing: EOP after 5 nibbles
      f0 = fe_rise;
      h0 = fe_hi;
      send_pkt(72'h12345, 5, 1'b1, miss);
      check("fr_miss", 72'(miss), 72'd0);
      tick();
      tick();
      check("fr_pulses", 72'(fe_rise - f0), 72'd1);
      check("fr_width", 72'(fe_hi - h0), 72'd1);
      check("fr_vld", 72'(vld), 72'd0);
      good_pkt("fr_next", 2);

      // framing: EOP while idle
      f0 = fe_rise;
      send_sym(EOP, 20, cyc);
      tick();
      check("idle_eop_ack", 72'(cyc != 0), 72'd1);
      check("idle_eop_fe", 72'(fe_rise - f0), 72'd1);
      good_pkt("idle_next", 1);

      // invalid 3-wire symbol mid-packet
      send_pkt(72'h321, 3, 1'b0, miss);
      f0 = fe_rise;
      send_sym(7'b0000111, 20, cyc);
      check("inv_ack", 72'(cyc != 0), 72'd1);
      send_pkt(72'h4567, 4, 1'b1, miss);
      check("inv_drop_miss", 72'(miss), 72'd0);
      tick();
      tick();
      check("inv_pulses", 72'(fe_rise - f0), 72'd1);
      check("inv_vld", 72'(vld), 72'd0);
      good_pkt("inv_next", 3);

      // all-zero short packet: even parity
      p0 = pe_hi;
      send_pkt(72'h0, 10, 1'b1, miss);
      check("par_miss", 72'(miss), 72'd0);
      tick();
      tick();
`ifdef SPINN_RX_PARITY_CHK_EN
      check("par_pulse", 72'(pe_hi - p0), 72'd1);
      check("par_vld", 72'(vld), 72'd0);
`else
      check("par_pulse", 72'(pe_hi - p0), 72'd0);
      check("par_vld", 72'(vld), 72'd1);
      check("par_data", data, 72'd0);
      pop("par_pop");
`endif

      // reset mid-packet discards the partial packet
      send_pkt(72'h555, 3, 1'b0, miss);
      rst_n = 1'b0;
      tick();
      check("mrst_ack", 72'(ack), 72'd0);
      send_sym(codes[5], 6, cyc);
      check("mrst_no_ack", 72'(cyc), 72'd0);
      din = '0;
      tick();
      rst_n = 1'b1;
      tick();
      check("mrst_vld", 72'(vld), 72'd0);
      good_pkt("mrst_next", 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
